rf_shift_sequencer: RTL and testbench
=====================================

Name: rf_shift_sequencer

Overview:
- Multi-cycle controller that runs SLL/SRL/SRA shifts by 0..31 on the in-memory register file.
- The register file's shift unit moves a word by only 1 bit per pass, so each pass reads a source row onto the down bus, shifts it by 1 and writes it into rd.
- The sequencer issues exactly shamt passes and owns rs2_index, rd_index, write_en, data2bus_en, shift_en and id_rf_shift_controls while busy.
- It shares the array with the normal issue path through an rf_req/rf_grant handshake.

Parameters:
- IDX_W, 5, register index width.
- SHAMT_W, 5, shift-amount width; the maximum shift is 2^SHAMT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle launch pulse; sampled only in IDLE.
- shift_op  in  2  {dir,arith}: 00 SLL, 10 SRL, 11 SRA; 01 is illegal and treated as 00.
- rs1_idx  in  IDX_W  source register.
- rd_idx  in  IDX_W  destination register.
- shamt  in  SHAMT_W  shift amount.
- rf_grant  in  1  register file granted to the sequencer this cycle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rf_req  out  1  requesting register-file access.
- rf_rs2_index  out  IDX_W  row driven onto the down bus.
- rf_rd_index  out  IDX_W  row written.
- rf_write_en  out  1  row write strobe.
- rf_data2bus_en  out  1  read enable, down direction.
- rf_shift_en  out  1  shift unit enable.
- rf_shift_ctrl  out  2  latched shift_op.
- rf_copy_en  out  1  pass-through copy (shift disabled, data forwarded).

Behaviour:
- FSM states: IDLE, STEP, FIN.
- Reset: asynchronous assertion forces IDLE and clears all registered state. Every output is 0 in reset and in IDLE. Reset in mid-operation abandons the operation; no done pulse is issued.
- IDLE + start: latch shift_op, rs1, rd and shamt.
  - If rd==0, or shamt==0 with rd==rs1: go to FIN with no register-file access.
  - Otherwise: go to STEP, set steps_left=max(shamt,1), src=rs1.
- busy = (state != IDLE).
- rf_req = (state == STEP).
- STEP issue rule: a pass issues only in a cycle where rf_grant=1. While rf_grant=0, every rf_* strobe except rf_req is 0 and all state holds.
- On an issued pass:
  - rf_rs2_index=src, rf_rd_index=rd_l, rf_write_en=1, rf_data2bus_en=1.
  - If shamt_l!=0: rf_shift_en=1 and rf_shift_ctrl=op_l.
  - If shamt_l==0: rf_copy_en=1 and rf_shift_en=0.
  - Then src<=rd_l and steps_left<=steps_left-1.
  - When steps_left==1 at issue time, go to FIN next cycle.
- Strobes are combinational from state, rf_grant and the latched registers. Exactly one write is issued per granted STEP cycle.
- FIN: done=1 for exactly one cycle, busy=1, then IDLE.
- start while busy is ignored. A start in the same cycle as done (FIN) is also ignored; a new launch is accepted only from IDLE.
- Latency with continuous grant: shamt+1 cycles from start to done, or 1 cycle for the no-access cases.
- The counter never wraps: the max shamt of 31 gives 31 passes. steps_left is SHAMT_W bits wide and stops at 0.
- rf_grant dropping in the cycle after a pass has no effect on passes already written.

Optional Feature:
- Macro: RF_SHIFT_SEQ_PERF_EN.
- When defined, add the following, both cleared by reset:
  - Output perf_stall_cnt (16 bits): increments each STEP cycle with rf_grant=0 and saturates at 0xFFFF.
  - Output perf_ops_cnt (16 bits): increments on each done and wraps.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package rf_shift_seq_pkg holds:
  - typedef shift_op_e: SLL=2'b00, SRL=2'b10, SRA=2'b11.
  - typedef seq_state_e: IDLE, STEP, FIN.
  - localparam REG_ZERO=5'd0.
- One sub-module, rf_shift_step_ctr: loadable down-counter with an enable (the grant) and a last-step flag.
- The FSM and strobe decode stay in the top module.

Test Plan:
- SLL: rs1=5, rd=6, shamt=4, rf_grant held at 1.
  - Expect 4 writes with (rs2,rd) = (5,6), (6,6), (6,6), (6,6) and rf_shift_ctrl=00.
  - Expect done in cycle 5 after start and busy high for cycles 1-5.
- SRA: rs1=rd=7, shamt=31, rf_grant low on pass-cycles 3 and 10.
  - Expect exactly 31 writes, each with rf_shift_ctrl=11, and rf_req held high.
  - Expect done 34 cycles after start.
- rd=0, shamt=8 → no rf_write_en, done 1 cycle after start. Repeat with shamt=0 and rd==rs1=3 → same result.
- shamt=0, rs1=2, rd=9 → one pass with rf_copy_en=1, rf_shift_en=0, (rs2,rd)=(2,9), then done.
- Reset driven low during pass 2 of a shamt=5 op:
  - Expect every output 0 immediately and no done pulse.
  - After release, a new start runs normally.
- A second start issued while busy, and again in the FIN cycle → ignored. Only one done pulse; the latched operands are unchanged.

Source files
------------

// File: rtl/rf_shift_seq_pkg.sv
// Shared types for the register-file shift sequencer: shift opcodes,
// FSM state encoding and the hard-wired zero register index.
package rf_shift_seq_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b10,
    SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FIN  = 2'd2
  } seq_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The unused encoding 01 falls back to a logical left shift.
  function automatic shift_op_e norm_op(input logic [1:0] op);
    if (op == 2'b01) begin
      return SLL;
    end
    return shift_op_e'(op);
  endfunction

endpackage

// File: rtl/rf_shift_step_ctr.sv
// Loadable pass down-counter; decrements only on granted passes, never wraps
// below zero, and flags the final pass.
module rf_shift_step_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/rf_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller driving the 1-bit-per-pass register-file
// shift unit. Optional perf counters enabled by RF_SHIFT_SEQ_PERF_EN.
module rf_shift_sequencer
  import rf_shift_seq_pkg::*;
#(
  parameter int IDX_W   = 5,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         shift_op,
  input  logic [IDX_W-1:0]   rs1_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               rf_grant,
  output logic               busy,
  output logic               done,
  output logic               rf_req,
  output logic [IDX_W-1:0]   rf_rs2_index,
  output logic [IDX_W-1:0]   rf_rd_index,
  output logic               rf_write_en,
  output logic               rf_data2bus_en,
  output logic               rf_shift_en,
  output logic [1:0]         rf_shift_ctrl,
  output logic               rf_copy_en
`ifdef RF_SHIFT_SEQ_PERF_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_ops_cnt
`endif
);

  seq_state_e         state;
  shift_op_e          op_l;
  logic [IDX_W-1:0]   rd_l;
  logic [IDX_W-1:0]   src;
  logic [SHAMT_W-1:0] shamt_l;

  logic               no_access;
  logic               ctr_load;
  logic [SHAMT_W-1:0] ctr_load_val;
  logic               issue;
  logic [SHAMT_W-1:0] steps_left;
  logic               step_last;

  // Writing x0 is discarded and a zero shift onto itself is a no-op,
  // so neither needs the array.
  assign no_access = (rd_idx == IDX_W'(REG_ZERO)) ||
                     ((shamt == '0) && (rd_idx == rs1_idx));

  assign ctr_load     = (state == IDLE) && start && !no_access;
  assign ctr_load_val = (shamt == '0) ? SHAMT_W'(1) : shamt;
  assign issue        = (state == STEP) && rf_grant;

  rf_shift_step_ctr #(
    .W (SHAMT_W)
  ) u_step_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .en       (issue),
    .count    (steps_left),
    .last     (step_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rf_req  <= 1'b0;
      op_l    <= SLL;
      rd_l    <= '0;
      src     <= '0;
      shamt_l <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_l    <= norm_op(shift_op);
            rd_l    <= rd_idx;
            src     <= rs1_idx;
            shamt_l <= shamt;
            busy    <= 1'b1;
            if (no_access) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state  <= STEP;
              rf_req <= 1'b1;
            end
          end
        end
        STEP: begin
          // After the first pass the running value lives in rd.
          if (rf_grant) begin
            src <= rd_l;
            if (step_last) begin
              state  <= FIN;
              rf_req <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          rf_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rf_rs2_index   = '0;
    rf_rd_index    = '0;
    rf_write_en    = 1'b0;
    rf_data2bus_en = 1'b0;
    rf_shift_en    = 1'b0;
    rf_shift_ctrl  = 2'b00;
    rf_copy_en     = 1'b0;
    if (issue) begin
      rf_rs2_index   = src;
      rf_rd_index    = rd_l;
      rf_write_en    = 1'b1;
      rf_data2bus_en = 1'b1;
      if (shamt_l != '0) begin
        rf_shift_en   = 1'b1;
        rf_shift_ctrl = op_l;
      end else begin
        rf_copy_en = 1'b1;
      end
    end
  end

`ifdef RF_SHIFT_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_ops_cnt   <= '0;
    end else begin
      if ((state == STEP) && !rf_grant && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (done) begin
        perf_ops_cnt <= perf_ops_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_shift_sequencer.sv
// Randomized scoreboard bench for rf_shift_sequencer: a pass-list model
// queues expected writes and done events, a negedge monitor checks them.
module tb_rf_shift_sequencer;

  localparam int W = 16;
  localparam logic [W-1:0] DONE_EV = 16'h8000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] shift_op = 2'b00;
  logic [4:0] rs1_idx = '0;
  logic [4:0] rd_idx = '0;
  logic [4:0] shamt = '0;
  logic       rf_grant = 1'b0;

  logic       busy, done, rf_req;
  logic [4:0] rf_rs2_index, rf_rd_index;
  logic       rf_write_en, rf_data2bus_en, rf_shift_en, rf_copy_en;
  logic [1:0] rf_shift_ctrl;

  rf_shift_sequencer #(.IDX_W(5), .SHAMT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .shift_op       (shift_op),
    .rs1_idx        (rs1_idx),
    .rd_idx         (rd_idx),
    .shamt          (shamt),
    .rf_grant       (rf_grant),
    .busy           (busy),
    .done           (done),
    .rf_req         (rf_req),
    .rf_rs2_index   (rf_rs2_index),
    .rf_rd_index    (rf_rd_index),
    .rf_write_en    (rf_write_en),
    .rf_data2bus_en (rf_data2bus_en),
    .rf_shift_en    (rf_shift_en),
    .rf_shift_ctrl  (rf_shift_ctrl),
    .rf_copy_en     (rf_copy_en)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           start_cyc = 0;
  logic         exp_busy = 1'b0;
  logic         exp_req = 1'b0;
  int           vec_cnt = 0;
  int           err_cnt = 0;

  function automatic logic [W-1:0] wr_ev(input logic [4:0] rs2, input logic [4:0] rd,
                                         input logic [1:0] ctrl, input logic sh,
                                         input logic cp);
    return {1'b0, rs2, rd, ctrl, sh, cp, 1'b1};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int lat;
    if (!rst) begin
      vec_cnt++;
      if ({busy, done, rf_req, rf_rs2_index, rf_rd_index, rf_write_en, rf_data2bus_en,
           rf_shift_en, rf_shift_ctrl, rf_copy_en} !== '0) begin
        err_cnt++;
        $display("FAIL reset_outputs: got busy=%b done=%b req=%b we=%b rs2=%0d rd=%0d want all 0",
                 busy, done, rf_req, rf_write_en, rf_rs2_index, rf_rd_index);
      end
    end else begin
      vec_cnt++;
      if (busy !== exp_busy || rf_req !== exp_req) begin
        err_cnt++;
        $display("FAIL busy_req @%0d: got busy=%b req=%b want busy=%b req=%b",
                 cyc_cnt, busy, rf_req, exp_busy, exp_req);
      end
      vec_cnt++;
      if (!rf_write_en && ({rf_rs2_index, rf_rd_index, rf_data2bus_en, rf_shift_en,
                            rf_shift_ctrl, rf_copy_en} !== '0)) begin
        err_cnt++;
        $display("FAIL idle_strobes @%0d: got rs2=%0d rd=%0d d2b=%b sh=%b ctrl=%b cp=%b want 0",
                 cyc_cnt, rf_rs2_index, rf_rd_index, rf_data2bus_en, rf_shift_en,
                 rf_shift_ctrl, rf_copy_en);
      end
      if (rf_write_en) begin
        obs = {1'b0, rf_rs2_index, rf_rd_index, rf_shift_ctrl, rf_shift_en, rf_copy_en,
               rf_data2bus_en};
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_write @%0d: got %h want nothing", cyc_cnt, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            err_cnt++;
            $display("FAIL write @%0d: got %h want %h", cyc_cnt, obs, e);
          end
        end
      end
      if (done) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_done @%0d: got done=1 want 0", cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e !== DONE_EV) begin
            err_cnt++;
            $display("FAIL done_order @%0d: got done want event %h", cyc_cnt, e);
          end
        end
        if (lat_q.size() != 0) begin
          lat = lat_q.pop_front();
          vec_cnt++;
          if (cyc_cnt - start_cyc + 1 != lat) begin
            err_cnt++;
            $display("FAIL latency: got %0d want %0d", cyc_cnt - start_cyc + 1, lat);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rf_grant = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_drained(input string tag);
    vec_cnt++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain_%s: got %0d events %0d latencies left want 0", tag,
               exp_q.size(), lat_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rd,
                        input logic [4:0] sa, input int stall_pct, input int stall_a,
                        input int stall_b, input bit extra_starts);
    bit   pat[$];
    int   passes;
    int   granted;
    int   c;
    bit   g;
    logic [1:0] opn;
    // Reference model: list of passes straight from the operation rules.
    opn = (op == 2'b01) ? 2'b00 : op;
    if (rd == 5'd0 || (sa == 5'd0 && rd == rs1)) passes = 0;
    else if (sa == 5'd0) passes = 1;
    else passes = int'(sa);
    granted = 0;
    c = 1;
    while (granted < passes && c < 2000) begin
      if (c == stall_a || c == stall_b) g = 1'b0;
      else g = ($urandom_range(0, 99) >= stall_pct);
      pat.push_back(g);
      if (g) granted++;
      c++;
    end
    for (int i = 0; i < passes; i++) begin
      exp_q.push_back(wr_ev((i == 0) ? rs1 : rd, rd, (sa != 5'd0) ? opn : 2'b00,
                            sa != 5'd0, sa == 5'd0));
    end
    exp_q.push_back(DONE_EV);
    lat_q.push_back(pat.size() + 1);

    @(posedge clk);
    #1;
    start = 1'b1;
    shift_op = op;
    rs1_idx = rs1;
    rd_idx = rd;
    shamt = sa;
    @(posedge clk);
    #1;
    start_cyc = cyc_cnt;
    start = 1'b0;
    shift_op = 2'($urandom_range(0, 3));
    rs1_idx = 5'($urandom_range(0, 31));
    rd_idx = 5'($urandom_range(0, 31));
    shamt = 5'($urandom_range(0, 31));
    for (int k = 0; k < pat.size(); k++) begin
      rf_grant = pat[k];
      exp_busy = 1'b1;
      exp_req = 1'b1;
      start = (extra_starts && k == 1);
      @(posedge clk);
      #1;
    end
    // FIN cycle
    start = extra_starts;
    rf_grant = 1'($urandom_range(0, 1));
    exp_busy = 1'b1;
    exp_req = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_busy = 1'b0;
    exp_req = 1'b0;
    idle_cycles(2);
    check_drained("op");
  endtask

  task automatic reset_mid_op();
    @(posedge clk);
    #1;
    start = 1'b1;
    shift_op = 2'b10;
    rs1_idx = 5'd1;
    rd_idx = 5'd4;
    shamt = 5'd5;
    rf_grant = 1'b1;
    exp_q.push_back(wr_ev(5'd1, 5'd4, 2'b10, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_busy = 1'b1;
    exp_req = 1'b1;
    @(posedge clk);
    #1;
    #1;
    rst = 1'b0;
    exp_busy = 1'b0;
    exp_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(3);
    check_drained("reset");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    run_op(2'b00, 5'd5, 5'd6, 5'd4, 0, 0, 0, 1'b0);
    run_op(2'b11, 5'd7, 5'd7, 5'd31, 0, 3, 10, 1'b0);
    run_op(2'b10, 5'd3, 5'd0, 5'd8, 0, 0, 0, 1'b0);
    run_op(2'b00, 5'd3, 5'd3, 5'd0, 0, 0, 0, 1'b0);
    run_op(2'b10, 5'd2, 5'd9, 5'd0, 0, 0, 0, 1'b0);
    run_op(2'b01, 5'd8, 5'd11, 5'd3, 0, 0, 0, 1'b0);
    reset_mid_op();
    run_op(2'b11, 5'd1, 5'd4, 5'd5, 0, 0, 0, 1'b0);
    run_op(2'b10, 5'd3, 5'd12, 5'd6, 20, 0, 0, 1'b1);

    for (int n = 0; n < 30; n++) begin
      logic [1:0] op;
      logic [4:0] rs1, rd, sa;
      op = 2'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) rd = 5'd0;
      else if ($urandom_range(0, 4) == 0) rd = rs1;
      else rd = 5'($urandom_range(0, 31));
      sa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      run_op(op, rs1, rd, sa, $urandom_range(0, 40), 0, 0, bit'($urandom_range(0, 1)));
    end

    idle_cycles(3);
    check_drained("final");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #400000;
    err_cnt++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

endmodule
